// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO, back-to-back frames with no idle gap
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              div,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_n;
    logic [DIV_W-1:0] cnt, cnt_n, per, per_n, div_m1;
    logic ser_n, done_n, push, pop, can_pop, last;
    assign tx_ready = fifo_level != LW'(FIFO_DEPTH);
    assign push = tx_valid && tx_ready;
    assign can_pop = enable && fifo_level != '0;
    assign busy = state != IDLE;
    // per holds P-1 so the maximum divisor never needs an extra bit
    assign div_m1 = (div == '0) ? '0 : div - DIV_W'(1);
    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n = bit_cnt;
        per_n = per;
        ser_n = ser_tx;
        last = state != IDLE && cnt == '0;
        cnt_n = (state == IDLE) ? cnt : last ? per : cnt - DIV_W'(1);
        case (state)
            START: if (last) begin
                state_n = DATA;
                bit_n = '0;
                ser_n = shift[0];
            end
            DATA: if (last) begin
                if (bit_cnt == 3'd7) begin
                    state_n = STOP;
                    ser_n = 1'b1;
                end else begin
                    bit_n = bit_cnt + 3'd1;
                    shift_n = {1'b0, shift[7:1]};
                    ser_n = shift[1];
                end
            end
            STOP: if (last) state_n = IDLE;
            default: ;
        endcase
        // a pop from IDLE or the final stop cycle starts the next frame directly
        pop = can_pop && (state == IDLE || (state == STOP && last));
        if (pop) begin
            state_n = START;
            shift_n = mem[rd_ptr];
            per_n = div_m1;
            cnt_n = div_m1;
            ser_n = 1'b0;
        end
        done_n = state_n == STOP && cnt_n == '0;
    end
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            shift <= '0;
            bit_cnt <= '0;
            cnt <= '0;
            per <= '0;
            ser_tx <= 1'b1;
            tx_done <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_level <= '0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            bit_cnt <= bit_n;
            cnt <= cnt_n;
            per <= per_n;
            ser_tx <= ser_n;
            tx_done <= done_n;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= tx_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random-byte stimulus checked cycle by cycle against an ideal 8N1 waveform model
module tb_uart_tx_fifo;
    logic clock = 1'b0;
    logic resetb = 1'b0;
    logic enable = 1'b1;
    logic [15:0] div = 16'd4;
    logic [7:0] tx_data = '0;
    logic tx_valid = 1'b0;
    logic tx_ready, ser_tx, busy, tx_done;
    logic [2:0] fifo_level;
    int vectors = 0, errors = 0, cyc = 0, acc = 0, first_acc = 0;
    logic mon_en = 1'b0;
    logic [7:0] exp_b[$];
    int exp_p[$];
    int starts[$], dones[$];

    uart_tx_fifo #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clock(clock), .resetb(resetb), .enable(enable), .div(div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ser_tx(ser_tx), .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b, input int p);
        tx_data = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 20000 && !tx_ready; i++) @(negedge clock);
        check("push_ready", tx_ready, 1);
        @(negedge clock);
        acc = cyc;
        exp_b.push_back(b);
        exp_p.push_back(p);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (i < 20000 && (exp_b.size() != 0 || busy || fifo_level != 0)) begin
            @(negedge clock);
            i++;
        end
        check("idle_timeout", i < 20000, 1);
        check("frames_left", exp_b.size(), 0);
    endtask

    // ideal frame: start 0, data LSB first, stop 1, each P cycles; tx_done only in the final cycle
    initial begin : monitor
        logic [7:0] b;
        int p, k;
        logic e;
        forever begin
            @(negedge clock);
            if (!mon_en) continue;
            if (ser_tx) begin
                check("idle_busy", busy, 0);
                check("idle_done", tx_done, 0);
            end else if (exp_b.size() == 0) begin
                check("spurious_start", ser_tx, 1);
            end else begin
                b = exp_b.pop_front();
                p = exp_p.pop_front();
                starts.push_back(cyc);
                for (int c = 0; c < 10 * p; c++) begin
                    if (c > 0) @(negedge clock);
                    if (!mon_en) break;
                    k = c / p;
                    e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                    check("ser_bit", ser_tx, e);
                    check("done", tx_done, c == 10 * p - 1);
                    check("busy", busy, 1);
                    if (tx_done) dones.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int n;
        repeat (3) @(negedge clock);
        check("rst_ser", ser_tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_level", fifo_level, 0);
        resetb = 1'b1;
        mon_en = 1'b1;
        @(negedge clock);
        // single byte, start bit one cycle after acceptance
        div = 16'd4;
        push(8'hA5, 4);
        check("a5_pre", ser_tx, 1);
        @(negedge clock);
        check("a5_start", ser_tx, 0);
        wait_idle();
        // back-to-back frames exactly 10P apart
        starts.delete(); dones.delete();
        push(8'h55, 4);
        push(8'hAB, 4);
        wait_idle();
        check("b2b_starts", starts.size(), 2);
        check("b2b_dones", dones.size(), 2);
        if (starts.size() == 2) check("b2b_gap", starts[1] - starts[0], 40);
        if (dones.size() == 2) check("b2b_done_gap", dones[1] - dones[0], 40);
        // backpressure: 6th byte waits for the first pop at the end of frame 1
        div = 16'd2;
        for (int i = 0; i < 6; i++) begin
            push(8'($urandom), 2);
            if (i == 0) first_acc = acc;
            if (i == 4) begin
                check("bp_level", fifo_level, 4);
                check("bp_ready", tx_ready, 0);
            end
        end
        check("bp_accept6", acc - first_acc, 22);
        wait_idle();
        // enable gating
        div = 16'd8;
        push(8'h41, 8);
        push(8'h42, 8);
        repeat (30) @(negedge clock);
        enable = 1'b0;
        for (int i = 0; i < 200 && busy; i++) @(negedge clock);
        check("gate_idle", busy, 0);
        check("gate_level", fifo_level, 1);
        repeat (5) @(negedge clock);
        check("gate_hold_ser", ser_tx, 1);
        check("gate_hold_level", fifo_level, 1);
        enable = 1'b1;
        @(negedge clock);
        check("reen_start", ser_tx, 0);
        wait_idle();
        // div = 0 behaves as P = 1
        starts.delete(); dones.delete();
        div = 16'd0;
        push(8'($urandom), 1);
        wait_idle();
        if (starts.size() == 1 && dones.size() == 1) check("div0_len", dones[0] - starts[0], 9);
        else check("div0_frames", dones.size(), 1);
        // divisor change mid-frame applies to the next frame only
        starts.delete(); dones.delete();
        div = 16'd4;
        push(8'($urandom), 4);
        push(8'($urandom), 6);
        repeat (10) @(negedge clock);
        div = 16'd6;
        wait_idle();
        if (starts.size() == 2 && dones.size() == 2) begin
            check("div_chg_gap", starts[1] - starts[0], 40);
            check("div_chg_len2", dones[1] - starts[1], 59);
        end else check("div_chg_frames", dones.size(), 2);
        // random bursts
        for (int t = 0; t < 6; t++) begin
            div = 16'($urandom_range(0, 5));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                r = 8'($urandom);
                push(r, (div == 0) ? 1 : int'(div));
            end
            wait_idle();
        end
        // asynchronous reset during data bit 3
        div = 16'd4;
        push(8'($urandom), 4);
        push(8'($urandom), 4);
        repeat (17) @(negedge clock);
        #2;
        mon_en = 1'b0;
        resetb = 1'b0;
        #1;
        check("arst_ser", ser_tx, 1);
        check("arst_busy", busy, 0);
        check("arst_level", fifo_level, 0);
        check("arst_ready", tx_ready, 1);
        exp_b.delete();
        exp_p.delete();
        @(negedge clock);
        #2;
        resetb = 1'b1;
        mon_en = 1'b1;
        @(negedge clock);
        push(8'h3C, 4);
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
